// File: rtl/popcount_arbiter_if.sv
// Handshake bundle between requesters/result consumer and popcount_arbiter.
// Requesters sit on the master side; the arbiter uses the slave modport.
interface popcount_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      res_valid;
  logic                      res_ready;
  logic [ID_W-1:0]           res_id;
  logic [CNT_W-1:0]          res_count;
  logic [15:0]               res_total;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_id, res_count, res_total
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_id, res_count, res_total
  );
endinterface

// File: rtl/popcount_arbiter.sv
// Round-robin arbiter feeding a shared popcount with a one-deep result register.
// Define POPCOUNT_ARBITER_ACCUM_EN for per-requester saturating running totals.
module popcount_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
) (
  input logic               clk,
  input logic               rst,
  popcount_arbiter_if.slave bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [ID_W-1:0]          rr_ptr_q;
  logic [ID_W-1:0]          ptr_next;
  logic                     accept_en;
  logic                     found_p0;
  logic                     xfer_p0;
  logic [ID_W-1:0]          id_p0;
  logic [NUM_REQ-1:0]       grant_p0;
  logic [2*NUM_REQ-1:0]     valid_dbl;
  logic [2*NUM_REQ-1:0]     valid_rot;
  logic [DATA_W-1:0]        word_p0;
  logic [CNT_W-1:0]         cnt_p0;
  logic                     vld_p1;
  logic [ID_W-1:0]          id_p1;
  logic [CNT_W-1:0]         cnt_p1;

  function automatic logic [CNT_W-1:0] popcount(input logic [DATA_W-1:0] w);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      c = c + CNT_W'(w[i]);
    end
    return c;
  endfunction

  // Index arithmetic modulo NUM_REQ, which need not be a power of two.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input logic [ID_W:0]   off);
    logic [ID_W:0] s;
    s = {1'b0, base} + off;
    if (s >= NUM_REQ_W) begin
      s = s - NUM_REQ_W;
    end
    return s[ID_W-1:0];
  endfunction

`ifdef POPCOUNT_ARBITER_ACCUM_EN
  function automatic logic [15:0] sat_add16(input logic [15:0]      a,
                                            input logic [CNT_W-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
`endif

  // Stage p0: arbitration and popcount, purely combinational
  assign accept_en = !rst && ((state_q == EMPTY) || bus.res_ready);
  assign valid_dbl = {bus.req_valid, bus.req_valid};
  assign valid_rot = valid_dbl >> rr_ptr_q;

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    found_p0 = 1'b0;
    id_p0    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        found_p0 = 1'b1;
        id_p0    = wrap_add(rr_ptr_q, (ID_W+1)'(k));
      end
    end
  end

  assign xfer_p0  = found_p0 && accept_en;
  assign grant_p0 = xfer_p0 ? (NUM_REQ'(1) << id_p0) : '0;
  assign ptr_next = wrap_add(id_p0, (ID_W+1)'(1));

  always_comb begin
    word_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (id_p0 == ID_W'(i)) begin
        word_p0 = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign cnt_p0 = popcount(word_p0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (xfer_p0) state_d = FULL;
      FULL: begin
        if (xfer_p0) begin
          state_d = FULL;
        end else if (bus.res_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage p1: result register
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      id_p1    <= '0;
      cnt_p1   <= '0;
    end else if (xfer_p0) begin
      rr_ptr_q <= ptr_next;
      id_p1    <= id_p0;
      cnt_p1   <= cnt_p0;
    end
  end

  assign vld_p1 = (state_q == FULL);

`ifdef POPCOUNT_ARBITER_ACCUM_EN
  logic [15:0] acc_q [NUM_REQ];
  logic [15:0] tot_p0;
  logic [15:0] tot_p1;

  assign tot_p0 = sat_add16(acc_q[id_p0], cnt_p0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        acc_q[i] <= '0;
      end
      tot_p1 <= '0;
    end else if (xfer_p0) begin
      acc_q[id_p0] <= tot_p0;
      tot_p1       <= tot_p0;
    end
  end

  assign bus.res_total = tot_p1;
`else
  assign bus.res_total = 16'h0000;
`endif

  assign bus.req_ready = grant_p0;
  assign bus.res_valid = vld_p1;
  assign bus.res_id    = id_p1;
  assign bus.res_count = cnt_p1;

endmodule

// File: tb/tb_popcount_arbiter.sv
// Directed bench for popcount_arbiter (NUM_REQ=4, DATA_W=32), both accumulator builds.
module tb_popcount_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   acc [4];

  popcount_arbiter_if #(.NUM_REQ(4), .DATA_W(32)) bus ();

  popcount_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) acc[i] = 0;
  endtask

  function automatic logic [31:0] exp_total(input int g);
`ifdef POPCOUNT_ARBITER_ACCUM_EN
    return 32'(acc[g]);
`else
    return 32'(g - g);
`endif
  endfunction

  // New result from requester g with popcount c is expected now.
  task automatic chk_res(input string tag, input int g, input int c);
    acc[g] = (acc[g] + c > 65535) ? 65535 : acc[g] + c;
    chk({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    chk({tag, "_id"},    32'(bus.res_id),    32'(g));
    chk({tag, "_count"}, 32'(bus.res_count), 32'(c));
    chk({tag, "_total"}, 32'(bus.res_total), exp_total(g));
  endtask

  task automatic chk_hold(input string tag, input int g, input int c);
    chk({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    chk({tag, "_id"},    32'(bus.res_id),    32'(g));
    chk({tag, "_count"}, 32'(bus.res_count), 32'(c));
    chk({tag, "_total"}, 32'(bus.res_total), exp_total(g));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_id"},    32'(bus.res_id),    32'd0);
    chk({tag, "_count"}, 32'(bus.res_count), 32'd0);
    chk({tag, "_total"}, 32'(bus.res_total), 32'd0);
  endtask

  logic [3:0]  t32_grant [5];
  int          t32_id    [5];
  int          t32_cnt   [5];
  logic [31:0] sat_final;

  initial begin
    checks = 0;
    errors = 0;
    clear_model();
    t32_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    t32_id    = '{0, 1, 2, 3, 0};
    t32_cnt   = '{1, 2, 3, 4, 1};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;
    tick();
    tick();

    // Reset holds grants off even with every requester valid
    bus.req_valid = 4'hF;
    #1 chk("rst_ready", 32'(bus.req_ready), 32'd0);
    tick();
    chk_empty("rst_state");

    // Single all-ones word from requester 0
    rst                  = 1'b0;
    bus.req_valid        = 4'b0001;
    bus.req_data         = '0;
    bus.req_data[31:0]   = 32'hFFFF_FFFF;
    bus.res_ready        = 1'b1;
    #1 chk("t1_ready", 32'(bus.req_ready), 32'd1);
    tick();
    chk_res("t1", 0, 32);
    bus.req_valid = '0;
    #1 chk("idle_ready", 32'(bus.req_ready), 32'd0);
    tick();
    chk("t1_drain", 32'(bus.res_valid), 32'd0);

    // Zero word then two-bit word; rr_ptr=1 so the search wraps to 0
    bus.req_valid      = 4'b0001;
    bus.req_data[31:0] = 32'h0000_0000;
    #1 chk("zero_ready", 32'(bus.req_ready), 32'd1);
    tick();
    chk_res("zero", 0, 0);
    bus.req_data[31:0] = 32'h8000_0001;
    #1 chk("two_ready", 32'(bus.req_ready), 32'd1);
    tick();
    chk_res("two", 0, 2);
    bus.req_valid = '0;
    tick();
    chk("two_drain", 32'(bus.res_valid), 32'd0);

    // Round robin with all four requesters valid from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    bus.req_data  = {32'h0000_000F, 32'h0000_0007, 32'h0000_0003, 32'h0000_0001};
    bus.req_valid = 4'hF;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("rr_ready", 32'(bus.req_ready), 32'(t32_grant[i]));
      tick();
      chk_res("rr", t32_id[i], t32_cnt[i]);
    end
    bus.req_valid = '0;
    tick();
    chk("rr_drain", 32'(bus.res_valid), 32'd0);

    // Backpressure on requester 2
    bus.res_ready       = 1'b0;
    bus.req_valid       = 4'b0100;
    bus.req_data[95:64] = 32'h0000_000F;
    #1 chk("bp_ready", 32'(bus.req_ready), 32'b0100);
    tick();
    chk_res("bp", 2, 4);
    bus.req_data[95:64] = 32'h0000_00FF;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_stall_ready", 32'(bus.req_ready), 32'd0);
      tick();
      chk_hold("bp_stall", 2, 4);
    end
    bus.res_ready = 1'b1;
    #1 chk("bp_rel_ready", 32'(bus.req_ready), 32'b0100);
    tick();
    chk_res("bp_rel", 2, 8);
    bus.req_data[95:64] = 32'h0000_0000;
    #1 chk("bp_b2b_ready", 32'(bus.req_ready), 32'b0100);
    tick();
    chk_res("bp_b2b", 2, 0);
    bus.req_valid = '0;
    tick();
    chk("bp_drain", 32'(bus.res_valid), 32'd0);

    // Reset while FULL and stalled; rr_ptr was 3
    bus.req_valid = 4'hF;
    bus.res_ready = 1'b0;
    #1 chk("mid_ready", 32'(bus.req_ready), 32'b1000);
    tick();
    chk_res("mid", 3, 4);
    rst = 1'b1;
    #1 chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    tick();
    chk_empty("mid_rst");
    clear_model();
    rst           = 1'b0;
    bus.res_ready = 1'b1;
    #1 chk("post_rst_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    chk_res("post_rst", 0, 1);
    bus.req_valid = '0;
    tick();

    // Accumulator saturation for requester 1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    bus.req_valid       = 4'b0010;
    bus.req_data[63:32] = 32'hFFFF_FFFF;
    bus.res_ready       = 1'b1;
    for (int n = 0; n < 2049; n++) begin
      tick();
      chk_res("acc", 1, 32);
    end
`ifdef POPCOUNT_ARBITER_ACCUM_EN
    sat_final = 32'h0000_FFFF;
`else
    sat_final = 32'h0000_0000;
`endif
    chk("acc_final", 32'(bus.res_total), sat_final);
    bus.req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish, required finish before 500000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/popcount_arbiter.md
POPCOUNT_ARBITER -- requirements
Module: popcount_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the popcount datapath (2..8).
REQ-002 Parameter DATA_W, default 32, requester word width in bits.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port req_valid  input  NUM_REQ  per-requester word-available flag.
REQ-007 Port req_data  input  NUM_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 Port req_ready  output  NUM_REQ  one-hot grant; requester i's word is accepted when req_valid[i] and req_ready[i] are both high at a clock edge.
REQ-009 Port res_valid  output  1  result register holds an unconsumed result.
REQ-010 Port res_ready  input  1  downstream accepts the result when it and res_valid are both high.
REQ-011 Port res_id  output  clog2(NUM_REQ)  index of the requester that owns the result.
REQ-012 Port res_count  output  clog2(DATA_W)+1  number of set bits in the accepted word (0..DATA_W).
REQ-013 Port res_total  output  16  running total for res_id; driven per the Configuration section.

Function
REQ-014 The block SHALL have two states: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-015 req_ready SHALL be all-zero unless (EMPTY) or (FULL and res_ready=1).
REQ-016 When req_ready is enabled, exactly one bit SHALL be set: the first requester with req_valid high, searching from rr_ptr upward modulo NUM_REQ. With no req_valid high, req_ready SHALL be all-zero.
REQ-017 req_ready SHALL be combinational from req_valid, rr_ptr, state and res_ready; it SHALL never depend on req_data.
REQ-018 On a transfer from requester g, the following SHALL happen at the same edge:
- res_count is loaded with the popcount of the word;
- res_id is loaded with g;
- the state becomes FULL;
- rr_ptr becomes (g+1) mod NUM_REQ.
REQ-019 Latency SHALL be 1 cycle from the accepting edge to res_valid=1 with the result stable.
REQ-020 In FULL with res_ready=1 and no transfer, the state SHALL return to EMPTY at the next edge.
REQ-021 In FULL with res_ready=1 and a transfer in the same cycle, the state SHALL stay FULL and the result SHALL be replaced by the new one. This sustains one result per cycle.
REQ-022 In FULL with res_ready=0, res_valid, res_id, res_count and res_total SHALL hold unchanged.
REQ-023 rr_ptr SHALL change only on a transfer.
REQ-024 A requester that drops req_valid without a transfer SHALL lose nothing and SHALL not affect rr_ptr.
REQ-025 All-ones input SHALL give res_count=DATA_W; all-zeros input SHALL give res_count=0. There SHALL be no truncation.

Reset
REQ-026 rst=1 at an edge SHALL force EMPTY, res_valid=0, res_id=0, res_count=0, res_total=0 and rr_ptr=0; any pending result is discarded.
REQ-027 While rst is high, req_ready SHALL be all-zero and no transfer occurs. Reset asserted mid-stream SHALL take priority over a simultaneous transfer or consume.

Configuration
REQ-028 Macro POPCOUNT_ARBITER_ACCUM_EN.
REQ-029 When defined:
- the block SHALL keep one 16-bit saturating accumulator per requester, cleared by reset;
- on each transfer from g, accumulator[g] increases by the word's popcount, saturating at 16'hFFFF;
- res_total SHALL be loaded with the updated value of accumulator[g] at the same edge as res_count.
REQ-030 When undefined, no accumulators SHALL exist and res_total SHALL be constant 0.

Verification
REQ-031 Reset, then req_valid=4'b0001, req_data[31:0]=32'hFFFF_FFFF, res_ready=1:
- req_ready=4'b0001 in that cycle;
- next cycle res_valid=1, res_id=0, res_count=32.
REQ-032 All four requesters valid continuously, res_ready=1:
- grants SHALL be 0,1,2,3,0 on consecutive cycles;
- res_valid SHALL stay 1 from the second cycle onward.
REQ-033 Backpressure: requester 2 sends 32'h0000_000F while res_ready=0 for 3 cycles:
- res_count holds 4 and res_id holds 2;
- req_ready stays 0000 during the stall;
- releasing res_ready with req_valid still high gives back-to-back results.
REQ-034 rst pulsed while FULL with res_ready=0 and req_valid=4'b1111:
- next cycle res_valid=0 and rr_ptr=0;
- the first grant after reset goes to requester 0.
REQ-035 With POPCOUNT_ARBITER_ACCUM_EN, requester 1 sends 32'hFFFF_FFFF 2049 times:
- res_total reads 32, 64, ... and saturates at 16'hFFFF.
Without the macro, the same stimulus gives res_total=0 throughout.
REQ-036 Input 32'h0000_0000 followed by 32'h8000_0001 SHALL give res_count 0 then 2.
